// File: rtl/car_alarm_siren_driver_if.sv
// Request/abort inputs and horn/status outputs shared by the siren driver and its requester.
// The master side is the alarm decision logic; the slave side is the siren driver.
interface car_alarm_siren_driver_if;
  logic       CarAlarmSignal;
  logic       DisarmSignal;
  logic       HornOut;
  logic       AlarmActive;
  logic [7:0] TriggerCount;

  modport master (
    output CarAlarmSignal,
    output DisarmSignal,
    input  HornOut,
    input  AlarmActive,
    input  TriggerCount
  );

  modport slave (
    input  CarAlarmSignal,
    input  DisarmSignal,
    output HornOut,
    output AlarmActive,
    output TriggerCount
  );
endinterface

// File: rtl/car_alarm_siren_driver.sv
// Debounces the alarm request, then plays a fixed burst pattern on the horn followed by a cooldown.
// Optional macro SIREN_RETRIGGER_EN: a request still high at the end of the final burst restarts the pattern.
module car_alarm_siren_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ON_CYCLES       = 8,
  parameter int OFF_CYCLES      = 8,
  parameter int BURST_COUNT     = 5,
  parameter int COOLDOWN_CYCLES = 16
) (
  input logic                     clk,
  input logic                     reset,
  car_alarm_siren_driver_if.slave bus
);

  localparam int ON_OFF_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int PHASE_MAX  = (ON_OFF_MAX > COOLDOWN_CYCLES) ? ON_OFF_MAX : COOLDOWN_CYCLES;
  localparam int DEB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PHASE_W    = $clog2(PHASE_MAX + 1);
  localparam int BURST_W    = $clog2(BURST_COUNT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_QUALIFY  = 3'd1;
  localparam logic [2:0] S_HORN_ON  = 3'd2;
  localparam logic [2:0] S_HORN_OFF = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] ON_LAST    = PHASE_W'(ON_CYCLES - 1);
  localparam logic [PHASE_W-1:0] OFF_LAST   = PHASE_W'(OFF_CYCLES - 1);
  localparam logic [PHASE_W-1:0] COOL_LAST  = PHASE_W'(COOLDOWN_CYCLES - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_COUNT - 1);

  logic [2:0]         r_state;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic [PHASE_W-1:0] r_phase_cnt;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_horn;
  logic               r_active;
  logic [7:0]         r_trig_cnt;

  logic [2:0]         w_state_nxt;
  logic [DEB_W-1:0]   w_deb_nxt;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic [BURST_W-1:0] w_burst_nxt;
  logic               w_trig_inc;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_phase_nxt = r_phase_cnt;
    w_burst_nxt = r_burst_cnt;
    w_trig_inc  = 1'b0;

    if (bus.DisarmSignal) begin
      w_state_nxt = S_IDLE;
      w_deb_nxt   = '0;
      w_phase_nxt = '0;
      w_burst_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_deb_nxt   = '0;
          w_phase_nxt = '0;
          w_burst_nxt = '0;
          if (bus.CarAlarmSignal) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_state_nxt = S_HORN_ON;
              w_trig_inc  = 1'b1;
            end else begin
              w_state_nxt = S_QUALIFY;
              w_deb_nxt   = DEB_W'(1);
            end
          end
        end

        S_QUALIFY: begin
          if (!bus.CarAlarmSignal) begin
            w_state_nxt = S_IDLE;
            w_deb_nxt   = '0;
          end else if (r_deb_cnt == DEB_LAST) begin
            w_state_nxt = S_HORN_ON;
            w_deb_nxt   = '0;
            w_phase_nxt = '0;
            w_trig_inc  = 1'b1;
          end else begin
            w_deb_nxt = r_deb_cnt + DEB_W'(1);
          end
        end

        S_HORN_ON: begin
          if (r_phase_cnt == ON_LAST) begin
            w_phase_nxt = '0;
            w_burst_nxt = r_burst_cnt + BURST_W'(1);
            if (r_burst_cnt == BURST_LAST) begin
              w_state_nxt = S_COOLDOWN;
`ifdef SIREN_RETRIGGER_EN
              // A request still present replays the whole pattern without a new trigger.
              if (bus.CarAlarmSignal) begin
                w_state_nxt = S_HORN_OFF;
                w_burst_nxt = '0;
              end
`endif
            end else begin
              w_state_nxt = S_HORN_OFF;
            end
          end else begin
            w_phase_nxt = r_phase_cnt + PHASE_W'(1);
          end
        end

        S_HORN_OFF: begin
          if (r_phase_cnt == OFF_LAST) begin
            w_state_nxt = S_HORN_ON;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase_cnt + PHASE_W'(1);
          end
        end

        S_COOLDOWN: begin
          if (r_phase_cnt == COOL_LAST) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = '0;
            w_burst_nxt = '0;
          end else begin
            w_phase_nxt = r_phase_cnt + PHASE_W'(1);
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_deb_nxt   = '0;
          w_phase_nxt = '0;
          w_burst_nxt = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_deb_cnt   <= '0;
      r_phase_cnt <= '0;
      r_burst_cnt <= '0;
      r_horn      <= 1'b0;
      r_active    <= 1'b0;
      r_trig_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_burst_cnt <= w_burst_nxt;
      // Outputs decode the next state so they switch on the same edge as the state.
      r_horn      <= (w_state_nxt == S_HORN_ON);
      r_active    <= (w_state_nxt == S_HORN_ON) || (w_state_nxt == S_HORN_OFF);
      if (w_trig_inc && (r_trig_cnt != 8'hFF)) begin
        r_trig_cnt <= r_trig_cnt + 8'd1;
      end
    end
  end

  assign bus.HornOut      = r_horn;
  assign bus.AlarmActive  = r_active;
  assign bus.TriggerCount = r_trig_cnt;

endmodule

// File: doc/car_alarm_siren_driver.md
Name: car_alarm_siren_driver

Overview:
- Consumer end of the car-alarm request line: takes the combinational CarAlarmSignal and drives the physical horn.
- Qualifies (debounces) the request, then emits a fixed pattern of timed horn bursts, then a cooldown.
- A synchronous DisarmSignal (key fob) aborts the sequence.
- Sits between the alarm decision logic and the horn relay driver.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive high samples of CarAlarmSignal required to start the siren (>=1).
- ON_CYCLES, 8: cycles HornOut is high per burst (>=1).
- OFF_CYCLES, 8: cycles HornOut is low between bursts (>=1).
- BURST_COUNT, 5: number of ON phases per sequence (>=1).
- COOLDOWN_CYCLES, 16: horn-silent cycles after the last burst before re-qualification is allowed (>=1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- CarAlarmSignal  in  1  alarm request from the alarm decision logic; synchronous to clk.
- DisarmSignal  in  1  synchronous abort; highest priority.
- HornOut  out  1  registered horn relay drive.
- AlarmActive  out  1  registered; high in HORN_ON and HORN_OFF.
- TriggerCount  out  8  registered count of started sequences; saturates at 255.

Behaviour:
- Reset (async, active-high): state IDLE; HornOut=0, AlarmActive=0, TriggerCount=0; all internal counters 0. Outputs go low immediately, without waiting for a clock edge.
- States: IDLE, QUALIFY, HORN_ON, HORN_OFF, COOLDOWN. Outputs are registered and decoded from the next state, so each output changes on the same edge as its state change.
- DisarmSignal=1 at an edge, from any state: next state IDLE, HornOut=0, AlarmActive=0, counters cleared, TriggerCount held. Disarm overrides every other transition in that cycle.
- IDLE: debounce counter = 0.
  - CarAlarmSignal=1: debounce counter = 1, go to QUALIFY.
  - If DEBOUNCE_CYCLES==1, go straight to HORN_ON instead.
- QUALIFY:
  - CarAlarmSignal=0: go to IDLE, counter cleared.
  - CarAlarmSignal=1 and counter==DEBOUNCE_CYCLES-1: go to HORN_ON and increment TriggerCount (saturating).
  - Otherwise increment the counter.
- Debounce latency: the request is high at sampling edges k..k+DEBOUNCE_CYCLES-1, and HornOut rises at edge k+DEBOUNCE_CYCLES-1.
- HORN_ON: HornOut=1 for exactly ON_CYCLES cycles. At the end of the phase the burst counter increments.
  - If that was burst number BURST_COUNT, go to COOLDOWN.
  - Otherwise go to HORN_OFF.
- HORN_OFF: HornOut=0 for exactly OFF_CYCLES cycles, then go to HORN_ON.
- Sequence length: AlarmActive is high for BURST_COUNT*ON_CYCLES + (BURST_COUNT-1)*OFF_CYCLES cycles. No OFF phase follows the last burst.
- COOLDOWN: HornOut=0, AlarmActive=0 for COOLDOWN_CYCLES cycles, then go to IDLE. CarAlarmSignal is ignored here.
- Retrigger: a request that stays high after cooldown needs a full fresh debounce.
- CarAlarmSignal is ignored during HORN_ON and HORN_OFF; a sequence always completes unless disarmed or reset.
- Phase and cooldown counters are sized clog2(max parameter + 1); no wrap is possible within a phase.
- TriggerCount is cleared only by reset.

Optional Feature:
- Macro: SIREN_RETRIGGER_EN.
- Defined: if CarAlarmSignal=1 at the last edge of the final HORN_ON, go to HORN_OFF and restart the burst sequence. The burst counter clears and there is no cooldown; TriggerCount is not incremented. If CarAlarmSignal=0 at that edge, go to COOLDOWN as normal.
- Undefined: the final burst always goes to COOLDOWN.

Test Plan:
- Reset asserted between clock edges -> HornOut, AlarmActive and TriggerCount read 0 before the next edge; state IDLE.
- CarAlarmSignal high 3 cycles, then low (defaults) -> HornOut never rises; TriggerCount=0.
- CarAlarmSignal high 4 cycles, then low -> HornOut rises on the 4th sample edge.
  - Then 5 bursts of 8 high / 8 low, with no OFF after the 5th.
  - AlarmActive high 72 cycles, then 16 cooldown cycles; TriggerCount=1.
- Disarm pulsed at cycle 3 of the 2nd HORN_ON -> HornOut=0 and AlarmActive=0 at that edge.
  - A new alarm then needs 4 fresh high cycles; TriggerCount increments to 2.
- CarAlarmSignal held high continuously, macro undefined -> 72 active cycles, 16 cooldown, then 4 debounce cycles, then a new sequence; TriggerCount=2.
  - With SIREN_RETRIGGER_EN defined -> after the 5th burst, 8 OFF cycles then HORN_ON again; no cooldown; TriggerCount stays 1.
- Reset asserted mid HORN_ON after 300 triggers (TriggerCount saturated at 255) -> all outputs 0 asynchronously; after release a 4-cycle request restarts with TriggerCount=1.
